// File: rtl/iod_dly_pkg.sv
// Shared types for the IOD delay-line tap sequencer.
// Holds the FSM states, the tap-bank operation codes and the lane index width helper.
package iod_dly_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETUP,
    ST_MOVE,
    ST_WAIT,
    ST_DONE
  } seq_state_e;

  typedef enum logic [2:0] {
    TAP_NOP,
    TAP_INIT,
    TAP_INC,
    TAP_DEC,
    TAP_REVERT
  } tap_op_e;

  localparam logic DIR_INC = 1'b1;
  localparam logic DIR_DEC = 1'b0;

  function automatic int lane_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/iod_dly_tap_seq_if.sv
// Request/completion handshake plus the per-lane IOD delay-line controls.
// The slave modport is the sequencer view; master is the requester/IOD view.
interface iod_dly_tap_seq_if #(
  parameter int NUM_LANES = 2,
  parameter int TAP_W     = 8
);
  localparam int LW = iod_dly_pkg::lane_w(NUM_LANES);

  logic                         REQ_VALID;
  logic                         REQ_READY;
  logic [LW-1:0]                REQ_LANE;
  logic [TAP_W-1:0]             REQ_TAP;
  logic                         REQ_LOAD;
  logic                         DONE;
  logic                         DONE_ERR;
  logic                         BUSY;
  logic [NUM_LANES*TAP_W-1:0]   CUR_TAP;
  logic [NUM_LANES-1:0]         DELAY_LINE_MOVE;
  logic [NUM_LANES-1:0]         DELAY_LINE_DIRECTION;
  logic [NUM_LANES-1:0]         DELAY_LINE_LOAD;
  logic [NUM_LANES-1:0]         DELAY_LINE_OUT_OF_RANGE;

  modport slave (
    input  REQ_VALID, REQ_LANE, REQ_TAP, REQ_LOAD, DELAY_LINE_OUT_OF_RANGE,
    output REQ_READY, DONE, DONE_ERR, BUSY, CUR_TAP,
           DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD
  );

  modport master (
    output REQ_VALID, REQ_LANE, REQ_TAP, REQ_LOAD, DELAY_LINE_OUT_OF_RANGE,
    input  REQ_READY, DONE, DONE_ERR, BUSY, CUR_TAP,
           DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD
  );

endinterface

// File: rtl/iod_dly_tap_bank.sv
// Per-lane tap shadow registers: set-to-INIT, increment, decrement and revert of the last step.
// One operation per cycle on the addressed lane; result is visible the following cycle.
module iod_dly_tap_bank
  import iod_dly_pkg::*;
#(
  parameter  int NUM_LANES = 2,
  parameter  int TAP_W     = 8,
  parameter  int INIT_TAP  = 1,
  localparam int LW        = lane_w(NUM_LANES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  tap_op_e                    op,
  input  logic [LW-1:0]              op_lane,
  output logic [NUM_LANES*TAP_W-1:0] cur_tap
);

  logic [TAP_W-1:0] tap_q [NUM_LANES];
  logic [TAP_W-1:0] tap_d [NUM_LANES];
  logic             last_inc_q;
  logic             last_inc_d;

  always_comb begin
    last_inc_d = last_inc_q;
    if (op == TAP_INC) last_inc_d = 1'b1;
    if (op == TAP_DEC) last_inc_d = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      tap_d[i] = tap_q[i];
      if (op_lane == LW'(i)) begin
        case (op)
          TAP_INIT:   tap_d[i] = TAP_W'(INIT_TAP);
          TAP_INC:    tap_d[i] = tap_q[i] + TAP_W'(1);
          TAP_DEC:    tap_d[i] = tap_q[i] - TAP_W'(1);
          // Undo the most recent step, whichever way it went.
          TAP_REVERT: tap_d[i] = last_inc_q ? (tap_q[i] - TAP_W'(1)) : (tap_q[i] + TAP_W'(1));
          default:    tap_d[i] = tap_q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_inc_q <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) tap_q[i] <= TAP_W'(INIT_TAP);
    end else begin
      last_inc_q <= last_inc_d;
      for (int i = 0; i < NUM_LANES; i++) tap_q[i] <= tap_d[i];
    end
  end

  always_comb begin
    cur_tap = '0;
    for (int i = 0; i < NUM_LANES; i++) cur_tap[i*TAP_W +: TAP_W] = tap_q[i];
  end

endmodule

// File: rtl/iod_dly_tap_seq.sv
// Multi-lane IOD delay tap sequencer: turns "lane N to tap T" into spaced LOAD/MOVE/DIRECTION pulses.
// One request in flight; all outputs registered; DONE pulses one cycle, READY returns the cycle after.
module iod_dly_tap_seq
  import iod_dly_pkg::*;
#(
  parameter int NUM_LANES    = 2,
  parameter int TAP_W        = 8,
  parameter int MAX_TAP      = 127,
  parameter int INIT_TAP     = 1,
  parameter int MOVE_SPACING = 4
) (
  input  logic              FAB_CLK,
  input  logic              ARST_N,
  iod_dly_tap_seq_if.slave  bus
);

  localparam int LW = lane_w(NUM_LANES);

  // Reset asserts asynchronously and releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;
  logic       rst_n;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_n      = rst_sync_q[1];

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) rst_sync_q <= '0;
    else         rst_sync_q <= rst_sync_d;
  end

  seq_state_e           state_q, state_d;
  logic [LW-1:0]        lane_q, lane_d;
  logic [TAP_W-1:0]     tgt_q, tgt_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [NUM_LANES-1:0] dir_q, dir_d;
  logic [NUM_LANES-1:0] move_q, move_d;
  logic [NUM_LANES-1:0] load_q, load_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 ready_q, ready_d;

  tap_op_e                    tap_op;
  logic [LW-1:0]              tap_lane;
  logic [NUM_LANES*TAP_W-1:0] cur_tap;
  logic [TAP_W-1:0]           sel_tap;
  logic [TAP_W-1:0]           req_lane_tap;
  logic                       sel_oor;
  logic                       req_bad;
  logic signed [TAP_W:0]      delta_req;
  logic signed [TAP_W:0]      delta_load;
  tap_op_e                    step_op;

  function automatic logic [NUM_LANES-1:0] lane_mask(input logic [LW-1:0] l);
    logic [NUM_LANES-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_LANES; i++) m[i] = (l == LW'(i));
    return m;
  endfunction

  function automatic logic [NUM_LANES-1:0] dir_vec(input logic [LW-1:0] l, input logic inc);
    logic [NUM_LANES-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_LANES; i++) v[i] = (l == LW'(i)) ? (inc ? DIR_INC : DIR_DEC) : DIR_DEC;
    return v;
  endfunction

  always_comb begin
    sel_tap      = '0;
    req_lane_tap = '0;
    sel_oor      = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_q == LW'(i)) begin
        sel_tap = cur_tap[i*TAP_W +: TAP_W];
        sel_oor = bus.DELAY_LINE_OUT_OF_RANGE[i];
      end
      if (bus.REQ_LANE == LW'(i)) req_lane_tap = cur_tap[i*TAP_W +: TAP_W];
    end
  end

  assign req_bad    = (int'(bus.REQ_TAP) > MAX_TAP) || (int'(bus.REQ_LANE) >= NUM_LANES);
  assign delta_req  = $signed({1'b0, bus.REQ_TAP}) - $signed({1'b0, req_lane_tap});
  assign delta_load = $signed({1'b0, tgt_q}) - $signed({1'b0, TAP_W'(INIT_TAP)});
  assign step_op    = ((|dir_q) == DIR_INC) ? TAP_INC : TAP_DEC;

  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    tgt_d    = tgt_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    move_d   = '0;
    load_d   = '0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    tap_op   = TAP_NOP;
    tap_lane = lane_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.REQ_VALID && ready_q) begin
          lane_d = bus.REQ_LANE;
          tgt_d  = bus.REQ_TAP;
          if (req_bad) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (bus.REQ_LOAD) begin
            state_d  = ST_LOAD;
            load_d   = lane_mask(bus.REQ_LANE);
            tap_op   = TAP_INIT;
            tap_lane = bus.REQ_LANE;
          end else begin
            // Direction is registered on entry so it is already valid during SETUP.
            state_d = ST_SETUP;
            dir_d   = dir_vec(bus.REQ_LANE, !delta_req[TAP_W] && (delta_req != '0));
          end
        end
      end
      ST_LOAD: begin
        state_d = ST_SETUP;
        dir_d   = dir_vec(lane_q, !delta_load[TAP_W] && (delta_load != '0));
      end
      ST_SETUP: begin
        if (sel_tap == tgt_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_MOVE;
          move_d  = lane_mask(lane_q);
          tap_op  = step_op;
        end
      end
      ST_MOVE: begin
        state_d = ST_WAIT;
        cnt_d   = 4'(MOVE_SPACING - 2);
      end
      ST_WAIT: begin
        if (sel_oor) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          tap_op  = TAP_REVERT;
        end else if (cnt_q == '0) begin
          if (sel_tap == tgt_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_MOVE;
            move_d  = lane_mask(lane_q);
            tap_op  = step_op;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        dir_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge FAB_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lane_q  <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= '0;
      move_q  <= '0;
      load_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      move_q  <= move_d;
      load_q  <= load_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  iod_dly_tap_bank #(
    .NUM_LANES (NUM_LANES),
    .TAP_W     (TAP_W),
    .INIT_TAP  (INIT_TAP)
  ) u_bank (
    .clk     (FAB_CLK),
    .rst_n   (rst_n),
    .op      (tap_op),
    .op_lane (tap_lane),
    .cur_tap (cur_tap)
  );

  assign bus.REQ_READY            = ready_q;
  assign bus.BUSY                 = ~ready_q;
  assign bus.DONE                 = done_q;
  assign bus.DONE_ERR             = err_q;
  assign bus.CUR_TAP              = cur_tap;
  assign bus.DELAY_LINE_MOVE      = move_q;
  assign bus.DELAY_LINE_DIRECTION = dir_q;
  assign bus.DELAY_LINE_LOAD      = load_q;

endmodule

// File: tb/tb_iod_dly_tap_seq.sv
// Directed bench for iod_dly_tap_seq: expected pulse/DONE events are queued at issue time
// and a negedge monitor pops and compares them whenever the DUT shows MOVE, LOAD or DONE.
module tb_iod_dly_tap_seq;

  logic FAB_CLK = 1'b0;
  logic ARST_N;

  always #5 FAB_CLK = ~FAB_CLK;

  iod_dly_tap_seq_if #(.NUM_LANES(2), .TAP_W(8)) bus ();
  iod_dly_tap_seq_if #(.NUM_LANES(3), .TAP_W(8)) bus2 ();

  iod_dly_tap_seq #(
    .NUM_LANES(2), .TAP_W(8), .MAX_TAP(127), .INIT_TAP(1), .MOVE_SPACING(4)
  ) dut (
    .FAB_CLK (FAB_CLK),
    .ARST_N  (ARST_N),
    .bus     (bus)
  );

  iod_dly_tap_seq #(
    .NUM_LANES(3), .TAP_W(8), .MAX_TAP(127), .INIT_TAP(1), .MOVE_SPACING(4)
  ) dut2 (
    .FAB_CLK (FAB_CLK),
    .ARST_N  (ARST_N),
    .bus     (bus2)
  );

  typedef struct {
    int          cyc;
    logic [1:0]  mv;
    logic [1:0]  ld;
    logic        dn;
    logic        er;
    logic [1:0]  dir;
    logic        chk_dir;
    logic [15:0] tap;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;
  int  t;

  always @(posedge FAB_CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void push_ev(input int c, input logic [1:0] mv, input logic [1:0] ld,
                                  input logic dn, input logic er, input logic [1:0] dir,
                                  input logic chk_dir, input logic [15:0] tap);
    ev_t e;
    e.cyc = c; e.mv = mv; e.ld = ld; e.dn = dn; e.er = er;
    e.dir = dir; e.chk_dir = chk_dir; e.tap = tap;
    exp_q.push_back(e);
  endfunction

  always @(negedge FAB_CLK) begin
    if ((bus.DELAY_LINE_MOVE != 2'b00) || (bus.DELAY_LINE_LOAD != 2'b00) || bus.DONE) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output cyc=%0d move=%b load=%b done=%b err=%b",
                 cyc, bus.DELAY_LINE_MOVE, bus.DELAY_LINE_LOAD, bus.DONE, bus.DONE_ERR);
      end else begin
        mon_e = exp_q.pop_front();
        chk("event_cycle", 64'(cyc), 64'(mon_e.cyc));
        chk("move", 64'(bus.DELAY_LINE_MOVE), 64'(mon_e.mv));
        chk("load", 64'(bus.DELAY_LINE_LOAD), 64'(mon_e.ld));
        chk("done", 64'(bus.DONE), 64'(mon_e.dn));
        chk("done_err", 64'(bus.DONE_ERR), 64'(mon_e.er));
        chk("cur_tap", 64'(bus.CUR_TAP), 64'(mon_e.tap));
        if (mon_e.chk_dir) chk("direction", 64'(bus.DELAY_LINE_DIRECTION), 64'(mon_e.dir));
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL missing_output: expected event at cyc %0d, still absent at cyc %0d", mon_e.cyc, cyc);
    end
  end

  task automatic issue(input int lane, input int tap, input logic ld, output int tt);
    int w;
    w = 0;
    @(negedge FAB_CLK);
    while (!bus.REQ_READY && w < 200) begin
      @(negedge FAB_CLK);
      w++;
    end
    if (!bus.REQ_READY) begin
      n_chk++;
      n_fail++;
      $display("FAIL ready_timeout: REQ_READY got 0 expected 1 after %0d cycles", w);
    end
    bus.REQ_VALID = 1'b1;
    bus.REQ_LANE  = 1'(lane);
    bus.REQ_TAP   = 8'(tap);
    bus.REQ_LOAD  = ld;
    tt = cyc;
    @(posedge FAB_CLK);
    #1;
    bus.REQ_VALID = 1'b0;
    bus.REQ_LOAD  = 1'b0;
  endtask

  task automatic drain(input string nm);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(negedge FAB_CLK);
      w++;
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_drain: %0d events pending expected 0", nm, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge FAB_CLK);
  endtask

  initial begin
    ARST_N = 1'b0;
    bus.REQ_VALID = 1'b0; bus.REQ_LANE = '0; bus.REQ_TAP = '0; bus.REQ_LOAD = 1'b0;
    bus.DELAY_LINE_OUT_OF_RANGE = '0;
    bus2.REQ_VALID = 1'b0; bus2.REQ_LANE = '0; bus2.REQ_TAP = '0; bus2.REQ_LOAD = 1'b0;
    bus2.DELAY_LINE_OUT_OF_RANGE = '0;
    repeat (3) @(negedge FAB_CLK);
    ARST_N = 1'b1;
    repeat (5) @(negedge FAB_CLK);

    chk("rst_ready", 64'(bus.REQ_READY), 64'd1);
    chk("rst_busy", 64'(bus.BUSY), 64'd0);
    chk("rst_done", 64'({bus.DONE, bus.DONE_ERR}), 64'd0);
    chk("rst_pulses", 64'({bus.DELAY_LINE_MOVE, bus.DELAY_LINE_LOAD, bus.DELAY_LINE_DIRECTION}), 64'd0);
    chk("rst_cur_tap", 64'(bus.CUR_TAP), 64'h0101);
    chk("rst_cur_tap_3lane", 64'(bus2.CUR_TAP), 64'h010101);

    // Lane0 1 -> 4, no load
    issue(0, 4, 1'b0, t);
    push_ev(t+2,  2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 16'h0102);
    push_ev(t+6,  2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 16'h0103);
    push_ev(t+10, 2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 16'h0104);
    push_ev(t+14, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0104);
    drain("lane0_up");

    // Lane1 1 -> 0
    issue(1, 0, 1'b0, t);
    push_ev(t+2, 2'b10, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 16'h0004);
    push_ev(t+6, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0004);
    drain("lane1_down");

    // Lane0 load then 1 -> 3
    issue(0, 3, 1'b1, t);
    push_ev(t+1,  2'b00, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0001);
    push_ev(t+3,  2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 16'h0002);
    push_ev(t+7,  2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 16'h0003);
    push_ev(t+11, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0003);
    drain("lane0_load");

    // Lane0 3 -> 1
    issue(0, 1, 1'b0, t);
    push_ev(t+2,  2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 16'h0002);
    push_ev(t+6,  2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 16'h0001);
    push_ev(t+10, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0001);
    drain("lane0_back");

    // Same tap: no moves, DONE at T+2
    issue(0, 1, 1'b0, t);
    push_ev(t+2, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0001);
    drain("lane0_zero");

    // Lane0 1 -> 10, out-of-range during the WAIT after the second move
    issue(0, 10, 1'b0, t);
    push_ev(t+2, 2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 16'h0002);
    push_ev(t+6, 2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 16'h0003);
    push_ev(t+8, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 16'h0002);
    while (cyc < t+7) @(negedge FAB_CLK);
    bus.DELAY_LINE_OUT_OF_RANGE = 2'b01;
    @(negedge FAB_CLK);
    bus.DELAY_LINE_OUT_OF_RANGE = 2'b00;
    drain("lane0_oor");

    // Illegal tap
    issue(0, 200, 1'b0, t);
    push_ev(t+1, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 16'h0002);
    drain("bad_tap");

    // Illegal lane on the 3-lane instance
    @(negedge FAB_CLK);
    bus2.REQ_VALID = 1'b1;
    bus2.REQ_LANE  = 2'd3;
    bus2.REQ_TAP   = 8'd5;
    @(posedge FAB_CLK);
    #1;
    bus2.REQ_VALID = 1'b0;
    @(negedge FAB_CLK);
    chk("bad_lane_done", 64'({bus2.DONE, bus2.DONE_ERR}), 64'b11);
    chk("bad_lane_pulses", 64'({bus2.DELAY_LINE_MOVE, bus2.DELAY_LINE_LOAD}), 64'd0);
    chk("bad_lane_cur_tap", 64'(bus2.CUR_TAP), 64'h010101);

    // Long request on lane1 interrupted by reset at T+5
    issue(1, 100, 1'b0, t);
    push_ev(t+2, 2'b10, 2'b00, 1'b0, 1'b0, 2'b10, 1'b1, 16'h0102);
    while (cyc < t+5) @(negedge FAB_CLK);
    ARST_N = 1'b0;
    #1;
    chk("arst_ready", 64'({bus.REQ_READY, bus.BUSY}), 64'b10);
    chk("arst_outputs", 64'({bus.DONE, bus.DELAY_LINE_MOVE, bus.DELAY_LINE_LOAD, bus.DELAY_LINE_DIRECTION}), 64'd0);
    chk("arst_cur_tap", 64'(bus.CUR_TAP), 64'h0101);
    @(negedge FAB_CLK);
    ARST_N = 1'b1;
    repeat (20) @(negedge FAB_CLK);
    chk("arst_pending", 64'(exp_q.size()), 64'd0);

    // Recovery: load lane0 then 1 -> 2
    issue(0, 2, 1'b1, t);
    push_ev(t+1, 2'b00, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0101);
    push_ev(t+3, 2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 16'h0102);
    push_ev(t+7, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0102);
    drain("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
